// File: rtl/ita_stream_addressgen_if.sv
// Address stream from the ITA address generator to a streamer's TCDM request logic.
// Valid/ready handshake; master drives addr/valid, slave drives ready.
interface ita_stream_addressgen_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  valid;
    logic                  ready;

    modport master (output addr, output valid, input ready);
    modport slave  (input addr, input valid, output ready);
endinterface

// File: rtl/ita_stream_addressgen.sv
// Strided 1D/2D address walker for one ITA HWPE streamer port.
// Define ITA_ADDRGEN_3D_EN to add the d2 (outer) dimension.
module ita_stream_addressgen #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  req_start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  tot_len_i,
    input  logic [ADDR_WIDTH-1:0] d0_stride_i,
    input  logic [LEN_WIDTH-1:0]  d0_len_i,
    input  logic [ADDR_WIDTH-1:0] d1_stride_i,
    input  logic [LEN_WIDTH-1:0]  d1_len_i,
    input  logic [ADDR_WIDTH-1:0] d2_stride_i,
    input  logic [1:0]            dim_enable_1h_i,
    ita_stream_addressgen_if.master addr_if,
    output logic                  ready_start_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr, r_d1_base, r_d0_stride, r_d1_stride;
    logic [LEN_WIDTH-1:0]  r_tot_len, r_d0_len, r_d1_len;
    logic [LEN_WIDTH-1:0]  r_tot_cnt, r_d0_cnt, r_d1_cnt;
    logic                  r_dim0;

    logic                  w_accept, w_hs, w_last, w_d0_wrap;
    logic [ADDR_WIDTH-1:0] w_d1_base_inc;

`ifdef ITA_ADDRGEN_3D_EN
    logic [ADDR_WIDTH-1:0] r_d2_base, r_d2_stride, w_d2_base_inc;
    logic                  r_dim1, w_d1_wrap;

    assign w_d1_wrap     = r_dim1 && (r_d1_cnt == r_d1_len - LEN_WIDTH'(1));
    assign w_d2_base_inc = r_d2_base + r_d2_stride;
`else
    logic w_unused;
    assign w_unused = ^{d2_stride_i, dim_enable_1h_i[1]};
`endif

    assign ready_start_o = (r_state != RUN);
    assign done_o        = (r_state == FINISH);
    assign addr_if.valid = (r_state == RUN);
    assign addr_if.addr  = r_addr;

    assign w_accept      = ready_start_o && req_start_i && !clear_i;
    assign w_hs          = addr_if.valid && addr_if.ready;
    assign w_last        = (r_tot_cnt == r_tot_len - LEN_WIDTH'(1));
    // A zero d0_len never matches len-1 within a walk, so it reads as "never wrap".
    assign w_d0_wrap     = r_dim0 && (r_d0_cnt == r_d0_len - LEN_WIDTH'(1));
    assign w_d1_base_inc = r_d1_base + r_d1_stride;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FINISH: begin
                if (req_start_i) w_state_nxt = (tot_len_i == '0) ? FINISH : RUN;
                else             w_state_nxt = IDLE;
            end
            RUN:     if (w_hs && w_last) w_state_nxt = FINISH;
            default: w_state_nxt = IDLE;
        endcase
        if (clear_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_d1_base   <= '0;
            r_d0_stride <= '0;
            r_d1_stride <= '0;
            r_tot_len   <= '0;
            r_d0_len    <= '0;
            r_d1_len    <= '0;
            r_tot_cnt   <= '0;
            r_d0_cnt    <= '0;
            r_d1_cnt    <= '0;
            r_dim0      <= 1'b0;
`ifdef ITA_ADDRGEN_3D_EN
            r_d2_base   <= '0;
            r_d2_stride <= '0;
            r_dim1      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (clear_i) begin
                r_tot_cnt <= '0;
                r_d0_cnt  <= '0;
                r_d1_cnt  <= '0;
            end else if (w_accept) begin
                r_addr      <= base_addr_i;
                r_d1_base   <= base_addr_i;
                r_d0_stride <= d0_stride_i;
                r_d1_stride <= d1_stride_i;
                r_tot_len   <= tot_len_i;
                r_d0_len    <= d0_len_i;
                r_d1_len    <= d1_len_i;
                r_tot_cnt   <= '0;
                r_d0_cnt    <= '0;
                r_d1_cnt    <= '0;
                r_dim0      <= dim_enable_1h_i[0];
`ifdef ITA_ADDRGEN_3D_EN
                r_d2_base   <= base_addr_i;
                r_d2_stride <= d2_stride_i;
                r_dim1      <= dim_enable_1h_i[1];
`endif
            end else if (w_hs) begin
                r_tot_cnt <= r_tot_cnt + LEN_WIDTH'(1);
                if (!w_d0_wrap) begin
                    r_d0_cnt <= r_d0_cnt + LEN_WIDTH'(1);
                    r_addr   <= r_addr + r_d0_stride;
                end else begin
                    r_d0_cnt <= '0;
`ifdef ITA_ADDRGEN_3D_EN
                    if (w_d1_wrap) begin
                        r_d1_cnt  <= '0;
                        r_d2_base <= w_d2_base_inc;
                        r_d1_base <= w_d2_base_inc;
                        r_addr    <= w_d2_base_inc;
                    end else
`endif
                    begin
                        r_d1_cnt  <= r_d1_cnt + LEN_WIDTH'(1);
                        r_d1_base <= w_d1_base_inc;
                        r_addr    <= w_d1_base_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ita_stream_addressgen.sv
// Directed bench for ita_stream_addressgen; expected addresses are hand-computed.
// Set ITA_ADDRGEN_3D_EN consistently for bench and RTL to exercise the d2 dimension.
module tb_ita_stream_addressgen;

    logic        clk = 1'b0;
    logic        rst, clear, req;
    logic [31:0] base_addr, tot_len, d0_stride, d0_len, d1_stride, d1_len, d2_stride;
    logic [1:0]  dim;
    logic        ready_start, done;
    int          checks = 0;
    int          errors = 0;

    ita_stream_addressgen_if #(.ADDR_WIDTH(32)) aif ();

    ita_stream_addressgen #(.ADDR_WIDTH(32), .LEN_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_start_i(req),
        .base_addr_i(base_addr), .tot_len_i(tot_len),
        .d0_stride_i(d0_stride), .d0_len_i(d0_len),
        .d1_stride_i(d1_stride), .d1_len_i(d1_len),
        .d2_stride_i(d2_stride), .dim_enable_1h_i(dim),
        .addr_if(aif.master), .ready_start_o(ready_start), .done_o(done)
    );

    always #5 clk = ~clk;

    task step;
        @(posedge clk);
        #1;
    endtask

    // Configuration is scrambled right after acceptance to prove it was sampled.
    task start(input logic [31:0] b, tl, s0, l0, s1, l1, s2, input logic [1:0] dm);
        base_addr = b; tot_len = tl; d0_stride = s0; d0_len = l0;
        d1_stride = s1; d1_len = l1; d2_stride = s2; dim = dm; req = 1'b1;
        step;
        req = 1'b0; base_addr = 32'hDEAD_BEE0; tot_len = 32'd3; d0_stride = 32'h40;
        d0_len = 32'd1; d1_stride = 32'h400; d1_len = 32'd1; d2_stride = 32'h7000; dim = 2'b10;
    endtask

    task test_reset;
        rst = 1'b1; clear = 1'b0; req = 1'b0; aif.ready = 1'b1;
        base_addr = '0; tot_len = '0; d0_stride = '0; d0_len = '0;
        d1_stride = '0; d1_len = '0; d2_stride = '0; dim = '0;
        step; step;
        checks++;
        if (aif.valid !== 1'b0 || done !== 1'b0 || ready_start !== 1'b1 || aif.addr !== 32'h0) begin
            errors++;
            $display("FAIL reset got v=%b d=%b rs=%b a=%h exp v=0 d=0 rs=1 a=0",
                     aif.valid, done, ready_start, aif.addr);
        end
        rst = 1'b0;
        step;
        checks++;
        if (aif.valid !== 1'b0 || ready_start !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset got v=%b rs=%b exp v=0 rs=1", aif.valid, ready_start);
        end
    endtask

    task test_1d;
        logic [31:0] exp [4];
        exp = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
        start(32'h1000, 4, 8, 4, 0, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aif.valid !== 1'b1 || aif.addr !== exp[i] || ready_start !== 1'b0) begin
                errors++;
                $display("FAIL 1d_addr[%0d] got v=%b a=%h rs=%b exp v=1 a=%h rs=0",
                         i, aif.valid, aif.addr, ready_start, exp[i]);
            end
            step;
        end
        checks++;
        if (aif.valid !== 1'b0 || done !== 1'b1 || ready_start !== 1'b1) begin
            errors++;
            $display("FAIL 1d_done got v=%b d=%b rs=%b exp v=0 d=1 rs=1", aif.valid, done, ready_start);
        end
        step;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL 1d_done_pulse got d=%b exp d=0", done);
        end
    endtask

    task test_2d;
        logic [31:0] exp [4];
        exp = '{32'd0, 32'd128, 32'd16, 32'd144};
        start(32'd0, 4, 128, 2, 16, 2, 0, 2'b01);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aif.valid !== 1'b1 || aif.addr !== exp[i]) begin
                errors++;
                $display("FAIL 2d_addr[%0d] got v=%b a=%0d exp v=1 a=%0d", i, aif.valid, aif.addr, exp[i]);
            end
            step;
        end
        checks++;
        if (done !== 1'b1 || aif.valid !== 1'b0) begin
            errors++;
            $display("FAIL 2d_done got d=%b v=%b exp d=1 v=0", done, aif.valid);
        end
        step;
    endtask

    task test_backpressure;
        logic [31:0] exp [4];
        int          hs, dn;
        exp = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
        hs = 0; dn = 0;
        start(32'h1000, 4, 8, 4, 0, 0, 0, 2'b00);
        step;                       // first address taken with ready high
        hs++;
        aif.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aif.valid !== 1'b1 || aif.addr !== 32'h1008) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b a=%h exp v=1 a=1008", i, aif.valid, aif.addr);
            end
            step;
        end
        aif.ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (aif.valid !== 1'b1 || aif.addr !== exp[i]) begin
                errors++;
                $display("FAIL bp_addr[%0d] got v=%b a=%h exp v=1 a=%h", i, aif.valid, aif.addr, exp[i]);
            end
            if (aif.valid === 1'b1) hs++;
            step;
        end
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) dn++;
            step;
        end
        checks++;
        if (hs !== 4 || dn !== 1) begin
            errors++;
            $display("FAIL bp_counts got hs=%0d done=%0d exp hs=4 done=1", hs, dn);
        end
    endtask

    task test_zero_len;
        int vseen;
        vseen = 0;
        start(32'h2000, 0, 8, 4, 0, 0, 0, 2'b00);
        checks++;
        if (done !== 1'b1 || aif.valid !== 1'b0 || ready_start !== 1'b1) begin
            errors++;
            $display("FAIL zlen_done got d=%b v=%b rs=%b exp d=1 v=0 rs=1", done, aif.valid, ready_start);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            if (aif.valid === 1'b1) vseen++;
        end
        checks++;
        if (vseen !== 0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zlen_quiet got valid_cycles=%0d d=%b exp valid_cycles=0 d=0", vseen, done);
        end
    endtask

    task test_start_in_run;
        logic [31:0] exp [4];
        exp = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
        start(32'h1000, 4, 8, 4, 0, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aif.valid !== 1'b1 || aif.addr !== exp[i]) begin
                errors++;
                $display("FAIL run_req_addr[%0d] got v=%b a=%h exp v=1 a=%h", i, aif.valid, aif.addr, exp[i]);
            end
            if (i == 1) begin
                req = 1'b1; base_addr = 32'h5000; tot_len = 32'd1;
            end
            step;
            req = 1'b0;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL run_req_done got d=%b exp d=1", done);
        end
        step;
        checks++;
        if (aif.valid !== 1'b0 || ready_start !== 1'b1) begin
            errors++;
            $display("FAIL run_req_idle got v=%b rs=%b exp v=0 rs=1", aif.valid, ready_start);
        end
    endtask

    task test_start_in_finish;
        start(32'h1000, 2, 8, 4, 0, 0, 0, 2'b00);
        step; step;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL fin_done got d=%b exp d=1", done);
        end
        start(32'h2000, 2, 4, 0, 0, 0, 0, 2'b00);
        checks++;
        if (aif.valid !== 1'b1 || aif.addr !== 32'h2000 || done !== 1'b0) begin
            errors++;
            $display("FAIL fin_restart got v=%b a=%h d=%b exp v=1 a=2000 d=0", aif.valid, aif.addr, done);
        end
        step;
        checks++;
        if (aif.addr !== 32'h2004) begin
            errors++;
            $display("FAIL fin_second got a=%h exp a=2004", aif.addr);
        end
        step;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL fin_done2 got d=%b exp d=1", done);
        end
        step;
    endtask

    task test_clear;
        int dn;
        dn = 0;
        start(32'h1000, 4, 8, 4, 0, 0, 0, 2'b00);
        step; step;                 // two handshakes
        clear = 1'b1;
        step;
        clear = 1'b0;
        checks++;
        if (aif.valid !== 1'b0 || done !== 1'b0 || ready_start !== 1'b1) begin
            errors++;
            $display("FAIL clr_state got v=%b d=%b rs=%b exp v=0 d=0 rs=1", aif.valid, done, ready_start);
        end
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) dn++;
            step;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL clr_no_done got done=%0d exp done=0", dn);
        end
        start(32'h3000, 2, 8, 4, 0, 0, 0, 2'b00);
        checks++;
        if (aif.valid !== 1'b1 || aif.addr !== 32'h3000) begin
            errors++;
            $display("FAIL clr_restart got v=%b a=%h exp v=1 a=3000", aif.valid, aif.addr);
        end
        step;
        checks++;
        if (aif.addr !== 32'h3008) begin
            errors++;
            $display("FAIL clr_restart2 got a=%h exp a=3008", aif.addr);
        end
        step;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL clr_restart_done got d=%b exp d=1", done);
        end
        step;
    endtask

    task test_3d;
        logic [31:0] exp [8];
`ifdef ITA_ADDRGEN_3D_EN
        exp = '{32'd0, 32'd4, 32'd64, 32'd68, 32'd1024, 32'd1028, 32'd1088, 32'd1092};
`else
        exp = '{32'd0, 32'd4, 32'd64, 32'd68, 32'd128, 32'd132, 32'd192, 32'd196};
`endif
        start(32'd0, 8, 4, 2, 64, 2, 1024, 2'b11);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (aif.valid !== 1'b1 || aif.addr !== exp[i]) begin
                errors++;
                $display("FAIL 3d_addr[%0d] got v=%b a=%0d exp v=1 a=%0d", i, aif.valid, aif.addr, exp[i]);
            end
            step;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL 3d_done got d=%b exp d=1", done);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_1d;
        test_2d;
        test_backpressure;
        test_zero_len;
        test_start_in_run;
        test_start_in_finish;
        test_clear;
        test_3d;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ita_stream_addressgen.md
# ita_stream_addressgen

Address-generating responder for one ITA HWPE streamer port. It serves the control FSM's `req_start` / `addressgen_ctrl` requests and returns the `ready_start` / `done` flags the FSM waits on. Each accepted request is a 1D/2D (optionally 3D) strided walk of `tot_len` word addresses. The addresses are presented over a valid/ready handshake to the TCDM request logic of the input, weight, bias or output streamer.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of base address, strides and output address.
- `LEN_WIDTH`, 32, width of `tot_len`, `d0_len`, `d1_len` and all internal counters.

Ports:
- `clk_i` input 1: single clock; all logic is on the rising edge.
- `rst_i` input 1: reset; synchronous, active-high.
- `clear_i` input 1: synchronous abort/clear (driven from the HWPE `clear_o`).
- `req_start_i` input 1: start request; sampled only when `ready_start_o`=1.
- `base_addr_i` input ADDR_WIDTH: first address.
- `tot_len_i` input LEN_WIDTH: total addresses to emit.
- `d0_stride_i` input ADDR_WIDTH: inner-dimension increment.
- `d0_len_i` input LEN_WIDTH: inner-dimension length.
- `d1_stride_i` input ADDR_WIDTH: middle-dimension increment.
- `d1_len_i` input LEN_WIDTH: middle-dimension length.
- `d2_stride_i` input ADDR_WIDTH: outer-dimension increment; used only with `ITA_ADDRGEN_3D_EN`.
- `dim_enable_1h_i` input 2: bit0 enables d1 wrap; bit1 enables d2 wrap.
- `addr_o` output ADDR_WIDTH: current address.
- `addr_valid_o` output 1: `addr_o` valid.
- `addr_ready_i` input 1: consumer accepts `addr_o`.
- `ready_start_o` output 1: idle, may accept `req_start_i`.
- `done_o` output 1: one-cycle pulse after the last address handshake.

## Operation
- Request sampling: all configuration inputs are sampled into registers on the accepting `req_start_i` cycle. Later changes to them have no effect until the next request.
- FSM states:
  - IDLE: `ready_start_o`=1. On `req_start_i`, go to RUN; if `tot_len_i`=0, go to FINISH instead.
  - RUN: `addr_valid_o`=1. A handshake is `addr_valid_o && addr_ready_i`. On the handshake where `tot_cnt`=`tot_len`-1, go to FINISH.
  - FINISH: lasts one cycle. `done_o`=1 and `ready_start_o`=1. A `req_start_i` in this cycle is accepted; the next state is RUN, or FINISH if the new `tot_len` is 0. Otherwise the next state is IDLE.
- Address update, performed on each handshake (`addr_o` comes from a register; no multipliers):
  - If `dim_enable_1h[0]`=0, or `d0_cnt`≠`d0_len`-1: `d0_cnt`++ and `addr` += `d0_stride`.
  - Else `d0_cnt`=0 and the d1 rule applies:
    - If `dim_enable_1h[1]`=0 (or the macro is off), or `d1_cnt`≠`d1_len`-1: `d1_cnt`++, `d1_base` += `d1_stride`, `addr` = new `d1_base`.
    - Else (macro on only): `d1_cnt`=0, `d2_base` += `d2_stride`, `d1_base` = `addr` = new `d2_base`.
- Zero lengths: `d0_len`=0 or `d1_len`=0 means "never wrap" in that dimension.
- Width rules: all address arithmetic is modulo 2^ADDR_WIDTH, so wrap-around is silent. Counters are LEN_WIDTH bits.
- `clear_i` (any state) has priority over `req_start_i` and handshakes:
  - next state IDLE, all counters 0;
  - `addr_valid_o` and `done_o` are 0 from the next cycle;
  - no `done_o` is produced for the aborted request.
- `req_start_i` in RUN is ignored.

## Timing
- Reset values: `addr_o`=0, `addr_valid_o`=0, `done_o`=0, `ready_start_o`=1; state IDLE.
- Start latency: `req_start_i` accepted at cycle t gives `addr_valid_o`=1 with `addr_o`=`base_addr` at t+1.
- Throughput: one address per cycle while `addr_ready_i`=1.
- Backpressure: while `addr_valid_o`=1 and `addr_ready_i`=0, `addr_o` holds stable and `addr_valid_o` is not withdrawn.
- Last handshake at cycle t: `addr_valid_o`=0, `done_o`=1 and `ready_start_o`=1 at t+1; `done_o`=0 at t+2.
- `tot_len`=0 accepted at t: `done_o`=1 at t+1, and no valid address is ever presented.
- `ready_start_o` is combinational from state: 1 in IDLE and FINISH, 0 in RUN.

## Configuration
- `ITA_ADDRGEN_3D_EN` defined:
  - `d2_stride_i` is registered;
  - `dim_enable_1h_i[1]` enables the d1 wrap into d2 as described in Operation.
- Undefined:
  - `d2_stride_i` and `dim_enable_1h_i[1]` are ignored, and no d2 registers are built;
  - d1 never wraps, so `d1_cnt` increments until `tot_len` is reached.

## Test plan
- 1D weight fetch: base 0x1000, `d0_stride`=8, `d0_len`=4, `tot_len`=4, dim=00, ready always 1 → addresses 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles; `done_o` pulses on the next cycle together with `ready_start_o`=1.
- 2D output walk: base 0, `d0_stride`=128, `d0_len`=2, `d1_stride`=16, `d1_len`=2, `tot_len`=4, dim=01 → addresses 0, 128, 16, 144, then one `done_o` pulse.
- Backpressure: same as the 1D case with `addr_ready_i` low for 3 cycles on the second address → 0x1008 held stable with valid high for those cycles; total of 4 handshakes and 1 done.
- Edge cases:
  - `tot_len`=0 → `done_o` at t+1, `addr_valid_o` never 1.
  - `req_start_i` pulsed during RUN → ignored, address sequence unchanged.
  - `req_start_i` in the FINISH cycle → new walk begins the next cycle with no idle gap.
- `clear_i` after 2 of 4 handshakes → `addr_valid_o`=0 the next cycle, no `done_o`, `ready_start_o`=1; a subsequent request restarts at its base.
- With `ITA_ADDRGEN_3D_EN`: base 0, `d0_stride`=4, `d0_len`=2, `d1_stride`=64, `d1_len`=2, `d2_stride`=1024, dim=11, `tot_len`=8 → 0, 4, 64, 68, 1024, 1028, 1088, 1092. Without the macro, the same stimulus → 0, 4, 64, 68, 128, 132, 192, 196.
